// File: rtl/xy_route_demux.sv
// xy_route_demux: router input-side splitter (1-to-N).
//   Takes one AXI-Stream-style flit stream and decodes each routing header flit.
//   It computes the XY-routed output port from this router's coordinates and
//   locks that port for the header plus the announced number of body flits.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cur_x, cur_y                     this router's mesh coordinates (static)
//   in_tdata/tid/tdest/tuser         input flit fields
//   in_valid / in_ready              input handshake
//   out_tdata/tid/tdest/tuser        flit fields broadcast to every port
//   out_valid / out_ready            per-port handshake
//   cur_port                         selected (header cycle) or locked port
//   busy                             packet body in progress
//   drop_pulse                       orphan flit discarded this cycle
//   perf_clear / perf_flits          per-port transfer counters
//
// Optional feature macro: DEMUX_PERF_COUNTERS_EN enables the per-port counters.
//   When it is undefined, perf_flits reads 0 and perf_clear is ignored.
module xy_route_demux #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned DEST_WIDTH     = 4,
  parameter int unsigned USER_WIDTH     = 4,
  parameter int unsigned CHANNEL_NUMBER = 5,
  parameter int unsigned MAX_ROUTERS_X  = 4,
  parameter int unsigned MAX_ROUTERS_Y  = 4,
  parameter int unsigned ROUTING_HEADER = 4'hF,
  localparam int unsigned XW = $clog2(MAX_ROUTERS_X),
  localparam int unsigned YW = $clog2(MAX_ROUTERS_Y),
  localparam int unsigned PW = $clog2(CHANNEL_NUMBER)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [XW-1:0]                        cur_x,
  input  logic [YW-1:0]                        cur_y,
  input  logic [DATA_WIDTH-1:0]                in_tdata,
  input  logic [ID_WIDTH-1:0]                  in_tid,
  input  logic [DEST_WIDTH-1:0]                in_tdest,
  input  logic [USER_WIDTH-1:0]                in_tuser,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DATA_WIDTH-1:0]                out_tdata,
  output logic [ID_WIDTH-1:0]                  out_tid,
  output logic [DEST_WIDTH-1:0]                out_tdest,
  output logic [USER_WIDTH-1:0]                out_tuser,
  output logic [CHANNEL_NUMBER-1:0]            out_valid,
  input  logic [CHANNEL_NUMBER-1:0]            out_ready,
  output logic [PW-1:0]                        cur_port,
  output logic                                 busy,
  output logic                                 drop_pulse,
  input  logic                                 perf_clear,
  output logic [CHANNEL_NUMBER-1:0][31:0]      perf_flits
);

  localparam int unsigned W = XW + YW;

  if (DATA_WIDTH < 2 * W + 8) begin : g_width_check
    $error("xy_route_demux: DATA_WIDTH too small for routing header");
  end

  localparam logic [PW-1:0] P_LOCAL = PW'(0);
  localparam logic [PW-1:0] P_NORTH = PW'(1);
  localparam logic [PW-1:0] P_SOUTH = PW'(2);
  localparam logic [PW-1:0] P_EAST  = PW'(3);
  localparam logic [PW-1:0] P_WEST  = PW'(4);

  typedef enum logic {IDLE, BODY} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] lock_port_q, lock_port_d;
  logic [7:0]    remaining_q, remaining_d;

  logic [XW-1:0] tgt_x;
  logic [YW-1:0] tgt_y;
  logic [7:0]    hdr_count;
  logic          is_hdr;
  logic [PW-1:0] route_port;

  assign out_tdata = in_tdata;
  assign out_tid   = in_tid;
  assign out_tdest = in_tdest;
  assign out_tuser = in_tuser;

  assign tgt_y     = in_tdata[YW-1:0];
  assign tgt_x     = in_tdata[W-1:YW];
  assign hdr_count = in_tdata[2*W+7:2*W];
  assign is_hdr    = (in_tid == ID_WIDTH'(ROUTING_HEADER));
  assign busy      = (state_q == BODY);

  // XY routing: resolve the column first, then the row.
  always_comb begin
    route_port = P_LOCAL;
    if (tgt_x > cur_x)      route_port = P_EAST;
    else if (tgt_x < cur_x) route_port = P_WEST;
    else if (tgt_y > cur_y) route_port = P_SOUTH;
    else if (tgt_y < cur_y) route_port = P_NORTH;
  end

  always_comb begin
    out_valid   = '0;
    in_ready    = 1'b0;
    cur_port    = lock_port_q;
    drop_pulse  = 1'b0;
    state_d     = state_q;
    lock_port_d = lock_port_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_hdr) begin
            out_valid[route_port] = 1'b1;
            in_ready              = out_ready[route_port];
            cur_port              = route_port;
            if (out_ready[route_port]) begin
              lock_port_d = route_port;
              remaining_d = hdr_count;
              state_d     = (hdr_count == 8'd0) ? IDLE : BODY;
            end
          end else begin
            // Orphan flit: swallow it so the upstream is never blocked.
            in_ready   = 1'b1;
            drop_pulse = 1'b1;
          end
        end
      end
      BODY: begin
        // Any TID is payload here, including the header value.
        out_valid[lock_port_q] = in_valid;
        in_ready               = out_ready[lock_port_q];
        if (in_valid && out_ready[lock_port_q]) begin
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_port_q <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      remaining_q <= remaining_d;
    end
  end

`ifdef DEMUX_PERF_COUNTERS_EN
  logic [CHANNEL_NUMBER-1:0][31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
      if (perf_clear) perf_d[i] = '0;
      else if (out_valid[i] && out_ready[i]) perf_d[i] = perf_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_flits = perf_q;
`else
  logic perf_unused;
  assign perf_unused = perf_clear;
  assign perf_flits  = '0;
`endif

endmodule

// File: doc/xy_route_demux.md
Name: xy_route_demux

Overview:
- Router input-side splitter; the 1-to-N counterpart of the N-to-1 output arbiter.
- Accepts one AXI-Stream-style flit stream from a link or local port. Decodes the routing header flit and computes the XY-routed output port from this router's coordinates.
- Locks that port for the header plus the announced number of body flits, then releases to await the next header.

Parameters:
- DATA_WIDTH, 32, TDATA width.
- ID_WIDTH, 4, TID width.
- DEST_WIDTH, 4, TDEST width.
- USER_WIDTH, 4, TUSER width.
- CHANNEL_NUMBER, 5, output ports: 0=LOCAL, 1=NORTH, 2=SOUTH, 3=EAST, 4=WEST.
- MAX_ROUTERS_X, 4, mesh columns; XW=$clog2(MAX_ROUTERS_X).
- MAX_ROUTERS_Y, 4, mesh rows; YW=$clog2(MAX_ROUTERS_Y).
- ROUTING_HEADER, 4'hF, TID value that marks a header flit.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cur_x  in  XW  this router's column (static)
- cur_y  in  YW  this router's row (static)
- in_tdata/in_tid/in_tdest/in_tuser  in  DATA/ID/DEST/USER_WIDTH  input flit fields
- in_valid  in  1  input flit valid
- in_ready  out  1  input flit accepted
- out_tdata/out_tid/out_tdest/out_tuser  out  same widths  shared broadcast to all ports (= in_*)
- out_valid  out  [CHANNEL_NUMBER]  per-port valid
- out_ready  in  [CHANNEL_NUMBER]  per-port ready
- cur_port  out  $clog2(CHANNEL_NUMBER)  locked/selected port
- busy  out  1  packet in progress (state BODY)
- drop_pulse  out  1  one-cycle pulse when an orphan flit is discarded
- perf_clear  in  1  synchronous clear of perf counters (optional feature)
- perf_flits  out  [CHANNEL_NUMBER][32]  per-port transferred-flit counts

Behaviour:
- Header layout, with W=XW+YW:
  - target_y = TDATA[YW-1:0]; target_x = TDATA[W-1:YW].
  - source = TDATA[2W-1:W] (ignored here).
  - count = TDATA[2W+7:2W], the number of body flits following the header (0..255).
  - Elaboration error if DATA_WIDTH < 2W+8.
- Route function, combinational:
  - target_x > cur_x -> EAST; target_x < cur_x -> WEST.
  - Otherwise target_y > cur_y -> SOUTH; target_y < cur_y -> NORTH.
  - Otherwise LOCAL.
  - Unsigned compare; out-of-mesh targets are routed by the same rule.
- State machine: IDLE, BODY. Registers: state, lock_port, remaining[7:0].
- IDLE, in_valid with in_tid==ROUTING_HEADER:
  - p=route(header); out_valid[p]=1, others 0; in_ready=out_ready[p]; cur_port=p (combinational, zero added latency).
  - On transfer: lock_port<=p, remaining<=count.
  - count==0 -> stay IDLE; else -> BODY.
- IDLE, in_valid with non-header TID (orphan): in_ready=1, all out_valid=0, drop_pulse=1 that cycle; flit discarded.
- IDLE, !in_valid: all out_valid=0, in_ready=0, cur_port=lock_port.
- BODY:
  - out_valid[lock_port]=in_valid, others 0; in_ready=out_ready[lock_port]; cur_port=lock_port.
  - Every transfer decrements remaining regardless of TID; a header-TID flit inside BODY is payload.
  - Transfer with remaining==1 -> IDLE next cycle.
  - The next header may be presented the following cycle; no bubble beyond one flit per cycle.
- Stall: while in_valid && !in_ready, the upstream holds the flit stable; state and counters are unchanged.
- Reset values: state=IDLE, lock_port=0, remaining=0, drop_pulse=0, perf_flits=0.
  - All out_valid are 0 during and after reset until a header arrives.
- Reset mid-packet: aborts to IDLE. The remaining flits of that packet arrive as orphans and are dropped with drop_pulse.
- No combinational path from out_ready to out_valid.

Optional Feature:
- Macro DEMUX_PERF_COUNTERS_EN.
- Defined:
  - perf_flits[i] increments by 1 per out_valid[i]&&out_ready[i] transfer, headers included.
  - Counters wrap at 2^32.
  - perf_clear zeroes all counters next cycle; clear takes priority over a simultaneous increment.
- Undefined: perf_flits tied to 0, perf_clear ignored, no counter flops.

Test Plan:
1. cur=(1,1), header target (3,1) count=2, then 2 body flits, out_ready all 1 -> port 3 sees 3 valid beats on consecutive cycles; busy high for 2 cycles; IDLE after the last beat.
2. cur=(2,2), header target (2,2) count=0 -> LOCAL gets the header only; busy stays 0; a next header to (2,0) goes to NORTH on the following cycle.
3. Target (1,3) from (1,1), count=4; out_ready[2]=0 for 3 cycles after the 2nd body flit -> in_ready=0 for those cycles, out_tdata stable, remaining holds at 2, all 5 flits delivered exactly once.
4. Non-header flit presented in IDLE -> in_ready=1, drop_pulse=1 for 1 cycle, all out_valid=0; next header routes normally.
5. Packet A to EAST (count=1), then packet B header to WEST presented the cycle after A's last flit -> no idle cycle; out_valid[3] drops and out_valid[4] rises the same cycle; rst_n pulse during B's body -> IDLE; the rest of B's flits are dropped.
6. With DEMUX_PERF_COUNTERS_EN: after scenarios 1+2, perf_flits[3]=3 and perf_flits[0]=1; perf_clear with a coincident transfer -> all counters 0. Without the macro -> all counters read 0.
